// File: rtl/syn_add_seq.sv
// syn_add_seq: WIDTH-bit adder built by sequencing an external registered
// 8-bit adder one byte per cycle, LSB byte first, carry chained through the
// adder's registered cout. Owns the start/busy/done handshake and assembles
// the result.
// Optional build macro: SYN_ADD_SEQ_SIGNED_OVF_EN enables the signed overflow
// flag; without it ovf is tied to 0.
module syn_add_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ovf,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_cin,
  input  logic [7:0]       add_sum,
  input  logic             add_cout
);

  localparam int unsigned NB   = WIDTH / 8;
  localparam int unsigned IDXW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned SELW = IDXW + 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IDXW-1:0]   idx;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;
  logic              cin_reg;
  logic              last_slice;
  logic [SELW-1:0]   cur_lo;
  logic [SELW-1:0]   prev_lo;

  assign last_slice = (idx == IDXW'(NB - 1));
  assign cur_lo     = {idx, 3'b000};
  assign prev_lo    = {idx - IDXW'(1), 3'b000};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and adder drive; adder inputs are zero outside ISSUE
  always_comb begin
    state_nxt = state;
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        add_a   = a_reg[cur_lo +: 8];
        add_b   = b_reg[cur_lo +: 8];
        add_cin = (idx == IDXW'(0)) ? cin_reg : add_cout;
        if (last_slice) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, slice index, result assembly and handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      cin_reg   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= op_a;
            b_reg   <= op_b;
            cin_reg <= op_cin;
            idx     <= '0;
          end
        end
        ISSUE: begin
          // The adder's output for slice k-1 is available while issuing slice k
          if (idx != IDXW'(0)) begin
            result[prev_lo +: 8] <= add_sum;
          end
          idx <= last_slice ? '0 : idx + IDXW'(1);
        end
        DRAIN: begin
          result[WIDTH-1 -: 8] <= add_sum;
          carry_out            <= add_cout;
          done                 <= 1'b1;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

`ifdef SYN_ADD_SEQ_SIGNED_OVF_EN
  // Signed overflow: like-signed operands producing an opposite-signed sum
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (state == DRAIN) begin
      ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_sum[7] != a_reg[WIDTH-1]);
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_syn_add_seq.sv
// Self-checking bench for syn_add_seq with a behavioural registered 8-bit
// adder standing in for the shared Syn8bit next to the block.
module tb_syn_add_seq;

  localparam int unsigned W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          op_cin;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          carry_out;
  logic          ovf;
  logic [7:0]    add_a;
  logic [7:0]    add_b;
  logic          add_cin;
  logic [7:0]    add_sum;
  logic          add_cout;

  int            n_assert;
  int            n_fail;
  int            n_done;
  int            lat;
  int            done_base;
  logic [W+1:0]  sb_q[$];
  logic [W+1:0]  discard;

  syn_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .op_cin    (op_cin),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .ovf       (ovf),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout)
  );

  // Registered 8-bit adder, one cycle latency, no reset
  always @(posedge clk) begin
    {add_cout, add_sum} <= 9'(add_a) + 9'(add_b) + 9'(add_cin);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, carry, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0] s;
    logic       v;
    s = 33'(a) + 33'(b) + 33'(c);
`ifdef SYN_ADD_SEQ_SIGNED_OVF_EN
    v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
`else
    v = 1'b0;
`endif
    return {v, s};
  endfunction

  // Scoreboard: every done pops one expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [W+1:0] e;
      n_done++;
      check("sb_nonempty_on_done", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("result", 64'(result), 64'(e[W-1:0]));
        check("carry_out", 64'(carry_out), 64'(e[W]));
        check("ovf", 64'(ovf), 64'(e[W+1]));
      end
    end
  end

  // Called #1 after an edge with the DUT idle; accepted on the next edge
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    start  = 1'b1;
    op_a   = a;
    op_b   = b;
    op_cin = c;
    sb_q.push_back(model(a, b, c));
    @(posedge clk);
    #1;
    start  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
    op_cin = 1'($urandom);
  endtask

  // Counts edges until done is seen; bounded
  task automatic wait_done(input bit chk_busy, output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (done) return;
      if (chk_busy) check("busy_in_flight", 64'(busy), 64'd1);
    end
    check("done_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    n_done   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    op_cin   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_carry", 64'(carry_out), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_add_a", 64'(add_a), 64'd0);
    check("idle_add_b", 64'(add_b), 64'd0);
    check("idle_add_cin", 64'(add_cin), 64'd0);

    // 1: latency and busy window
    launch(32'h0000_00FF, 32'h0000_0001, 1'b0);
    check("busy_after_accept", 64'(busy), 64'd1);
    wait_done(1'b1, lat);
    check("latency_t1", 64'(lat), 64'd5);

    // 2: carry ripples through every slice
    @(posedge clk);
    #1;
    launch(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(1'b0, lat);

    // 3: start during the done cycle is accepted
    @(posedge clk);
    #1;
    launch(32'h1234_5678, 32'h1111_1111, 1'b1);
    wait_done(1'b0, lat);
    launch(32'h0000_000A, 32'h0000_000F, 1'b0);
    wait_done(1'b0, lat);
    check("latency_back_to_back", 64'(lat), 64'd5);

    // 4: start while busy is ignored
    @(posedge clk);
    #1;
    done_base = n_done;
    launch(32'h0000_003C, 32'h0000_003C, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    op_a  = 32'h0000_0064;
    op_b  = 32'h0000_0023;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1'b0, lat);
    check("latency_ignore_start", 64'(lat), 64'd3);
    repeat (10) @(posedge clk);
    #1;
    check("single_done", 64'(n_done - done_base), 64'd1);

    // 5: reset mid-operation at idx=2
    done_base = n_done;
    launch(32'hA5A5_A5A5, 32'h5A5A_5A5B, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    discard = sb_q.pop_back();
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_carry", 64'(carry_out), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(n_done - done_base), 64'd0);
    launch(32'h0000_0005, 32'h0000_0064, 1'b1);
    wait_done(1'b0, lat);
    check("latency_after_rst", 64'(lat), 64'd5);

    // 6: signed overflow boundary
    @(posedge clk);
    #1;
    launch(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(1'b0, lat);

    // A few random operations
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      launch($urandom, $urandom, 1'($urandom));
      wait_done(1'b0, lat);
    end

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
